// File: rtl/apb_ucpd_bmc_tx.sv
// apb_ucpd_bmc_tx: UCPD transmit line stage.
// Serialises 5-bit line symbols (LSB first) into a BMC waveform on the half-bit
// strobe from the UCPD clock generator. An optional preamble comes first and a
// three-tick closing tail comes last.
// Build option: define UCPD_TX_PREAMBLE_EN to send PREAMBLE_BITS alternating
// bits (first bit 0) before the data. Without it, IDLE goes straight to DATA.
// Ports:
//   ic_clk, ic_rst            clock, synchronous active-high reset
//   hbit_clk_red              half-bit strobe (one ic_clk wide), the line "tick"
//   tx_start, tx_abort        frame start request / abort into TAIL
//   sym_data/valid/last/ready symbol handshake (accept on valid & ready)
//   bmc_out, bmc_oe           line level and driver enable
//   bmc_en                    busy (state != IDLE)
//   tx_done, tx_underrun      one-cycle status pulses
module apb_ucpd_bmc_tx #(
   parameter int unsigned SYM_W         = 5,
   parameter int unsigned PREAMBLE_BITS = 64
) (
   input  logic             ic_clk,
   input  logic             ic_rst,
   input  logic             hbit_clk_red,
   input  logic             tx_start,
   input  logic             tx_abort,
   input  logic [SYM_W-1:0] sym_data,
   input  logic             sym_valid,
   input  logic             sym_last,
   output logic             sym_ready,
   output logic             bmc_out,
   output logic             bmc_oe,
   output logic             bmc_en,
   output logic             tx_done,
   output logic             tx_underrun
);

   localparam int unsigned BCNT_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_TAIL = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               phase_q, phase_d;
   logic               bmc_out_q, bmc_out_d;
   logic               bmc_oe_q, bmc_oe_d;
   logic               bmc_en_q, bmc_en_d;
   logic               tx_done_q, tx_done_d;
   logic               tx_underrun_q, tx_underrun_d;
   logic               sym_ready_q, sym_ready_d;
   logic               start_pend_q, start_pend_d;
   logic [SYM_W-1:0]   hold_data_q, hold_data_d;
   logic               hold_last_q, hold_last_d;
   logic               hold_valid_q, hold_valid_d;
   logic [SYM_W-1:0]   shift_data_q, shift_data_d;
   logic               shift_last_q, shift_last_d;
   logic               shift_valid_q, shift_valid_d;
   logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]         tail_cnt_q, tail_cnt_d;

   logic               accept;
   logic               hold_avail;
   logic [SYM_W-1:0]   hold_data_eff;
   logic               hold_last_eff;
   logic               start_go;
   logic               start_boundary;
   logic               data_boundary;
   logic               abort_go;

`ifdef UCPD_TX_PREAMBLE_EN
   localparam int unsigned PCNT_W = 7;
   logic [PCNT_W-1:0]  pre_cnt_q, pre_cnt_d;
   assign start_boundary = 1'b0;
`else
   logic               unused_pre_cfg;
   assign unused_pre_cfg = |PREAMBLE_BITS;
   assign start_boundary = start_go;
`endif

   // Hold accepts after a start request and while the frame is sending data.
   assign accept = sym_valid & ~hold_valid_q &
                   (((state_q == ST_IDLE) & start_pend_q) |
                    (state_q == ST_PRE) | (state_q == ST_DATA));

   // A symbol accepted on this edge is usable by a coincident bit boundary.
   assign hold_avail    = hold_valid_q | accept;
   assign hold_data_eff = hold_valid_q ? hold_data_q : sym_data;
   assign hold_last_eff = hold_valid_q ? hold_last_q : sym_last;

   assign start_go      = hbit_clk_red & start_pend_q & ~tx_abort & (state_q == ST_IDLE);
   assign data_boundary = start_boundary |
                          (hbit_clk_red & ~tx_abort & (state_q == ST_DATA) & ~phase_q);
   // TAIL is already closing the line, so abort only acts before it.
   assign abort_go      = tx_abort & (state_q != ST_IDLE) & (state_q != ST_TAIL);

   // Next-state and output logic.
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      bmc_out_d     = bmc_out_q;
      bmc_oe_d      = bmc_oe_q;
      tx_done_d     = 1'b0;
      tx_underrun_d = 1'b0;
      start_pend_d  = start_pend_q;
      hold_data_d   = hold_data_q;
      hold_last_d   = hold_last_q;
      hold_valid_d  = hold_valid_q;
      shift_data_d  = shift_data_q;
      shift_last_d  = shift_last_q;
      shift_valid_d = shift_valid_q;
      bit_cnt_d     = bit_cnt_q;
      tail_cnt_d    = tail_cnt_q;
`ifdef UCPD_TX_PREAMBLE_EN
      pre_cnt_d     = pre_cnt_q;
`endif

      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = sym_data;
         hold_last_d  = sym_last;
      end

      case (state_q)
         ST_IDLE: begin
            if (tx_abort) begin
               start_pend_d = 1'b0;
            end else if (start_go) begin
               start_pend_d = 1'b0;
               bmc_oe_d     = 1'b1;
`ifdef UCPD_TX_PREAMBLE_EN
               state_d      = ST_PRE;
               pre_cnt_d    = '0;
               bmc_out_d    = ~bmc_out_q;
               phase_d      = 1'b1;
`else
               state_d      = ST_DATA;
`endif
            end else if (tx_start) begin
               start_pend_d = 1'b1;
            end
         end

`ifdef UCPD_TX_PREAMBLE_EN
         ST_PRE: begin
            if (hbit_clk_red) begin
               if (!phase_q) begin
                  bmc_out_d = ~bmc_out_q;
                  phase_d   = 1'b1;
               end else begin
                  // Preamble bit k carries k[0].
                  if (pre_cnt_q[0]) bmc_out_d = ~bmc_out_q;
                  phase_d = 1'b0;
                  if (pre_cnt_q == PCNT_W'(PREAMBLE_BITS - 1)) begin
                     state_d   = ST_DATA;
                     pre_cnt_d = '0;
                  end else begin
                     pre_cnt_d = pre_cnt_q + PCNT_W'(1);
                  end
               end
            end
         end
`endif

         ST_DATA: begin
            // Second half-bit: mid-bit transition for a 1, then advance.
            if (hbit_clk_red && phase_q) begin
               if (shift_data_q[0]) bmc_out_d = ~bmc_out_q;
               phase_d      = 1'b0;
               shift_data_d = shift_data_q >> 1;
               if (bit_cnt_q == BCNT_W'(SYM_W - 1)) begin
                  bit_cnt_d     = '0;
                  shift_valid_d = 1'b0;
                  if (shift_last_q) begin
                     state_d    = ST_TAIL;
                     tail_cnt_d = 2'd0;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end
            end
         end

         ST_TAIL: begin
            if (hbit_clk_red) begin
               case (tail_cnt_q)
                  2'd0: begin
                     bmc_out_d  = ~bmc_out_q;
                     tail_cnt_d = 2'd1;
                  end
                  2'd1: begin
                     bmc_out_d  = 1'b0;
                     tail_cnt_d = 2'd2;
                  end
                  default: begin
                     bmc_oe_d   = 1'b0;
                     tx_done_d  = 1'b1;
                     state_d    = ST_IDLE;
                     tail_cnt_d = 2'd0;
                  end
               endcase
            end
         end

         default: begin
         end
      endcase

      // Bit boundary in DATA (also the very first tick when there is no preamble).
      if (data_boundary) begin
         if (shift_valid_q) begin
            bmc_out_d = ~bmc_out_q;
            phase_d   = 1'b1;
         end else if (hold_avail) begin
            shift_data_d  = hold_data_eff;
            shift_last_d  = hold_last_eff;
            shift_valid_d = 1'b1;
            hold_valid_d  = 1'b0;
            bit_cnt_d     = '0;
            bmc_out_d     = ~bmc_out_q;
            phase_d       = 1'b1;
         end else begin
            // Nothing to send: close the frame without a boundary toggle.
            tx_underrun_d = 1'b1;
            state_d       = ST_TAIL;
            tail_cnt_d    = 2'd0;
            phase_d       = 1'b0;
         end
      end

      // Abort overrides any tick or accept in the same cycle.
      if (abort_go) begin
         state_d       = ST_TAIL;
         tail_cnt_d    = 2'd0;
         phase_d       = 1'b0;
         bmc_out_d     = bmc_out_q;
         tx_underrun_d = 1'b0;
         hold_valid_d  = 1'b0;
         shift_valid_d = 1'b0;
         shift_data_d  = '0;
         bit_cnt_d     = '0;
`ifdef UCPD_TX_PREAMBLE_EN
         pre_cnt_d     = '0;
`endif
      end

      bmc_en_d    = (state_d != ST_IDLE);
      sym_ready_d = ~hold_valid_d;
   end

   // State register.
   always_ff @(posedge ic_clk) begin
      if (ic_rst) begin
         state_q       <= ST_IDLE;
         phase_q       <= 1'b0;
         bmc_out_q     <= 1'b0;
         bmc_oe_q      <= 1'b0;
         bmc_en_q      <= 1'b0;
         tx_done_q     <= 1'b0;
         tx_underrun_q <= 1'b0;
         sym_ready_q   <= 1'b1;
         start_pend_q  <= 1'b0;
         hold_data_q   <= '0;
         hold_last_q   <= 1'b0;
         hold_valid_q  <= 1'b0;
         shift_data_q  <= '0;
         shift_last_q  <= 1'b0;
         shift_valid_q <= 1'b0;
         bit_cnt_q     <= '0;
         tail_cnt_q    <= 2'd0;
`ifdef UCPD_TX_PREAMBLE_EN
         pre_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         bmc_out_q     <= bmc_out_d;
         bmc_oe_q      <= bmc_oe_d;
         bmc_en_q      <= bmc_en_d;
         tx_done_q     <= tx_done_d;
         tx_underrun_q <= tx_underrun_d;
         sym_ready_q   <= sym_ready_d;
         start_pend_q  <= start_pend_d;
         hold_data_q   <= hold_data_d;
         hold_last_q   <= hold_last_d;
         hold_valid_q  <= hold_valid_d;
         shift_data_q  <= shift_data_d;
         shift_last_q  <= shift_last_d;
         shift_valid_q <= shift_valid_d;
         bit_cnt_q     <= bit_cnt_d;
         tail_cnt_q    <= tail_cnt_d;
`ifdef UCPD_TX_PREAMBLE_EN
         pre_cnt_q     <= pre_cnt_d;
`endif
      end
   end

   assign bmc_out     = bmc_out_q;
   assign bmc_oe      = bmc_oe_q;
   assign bmc_en      = bmc_en_q;
   assign tx_done     = tx_done_q;
   assign tx_underrun = tx_underrun_q;
   assign sym_ready   = sym_ready_q;

endmodule

// File: tb/tb_apb_ucpd_bmc_tx.sv
// Bench for apb_ucpd_bmc_tx: random symbols and strobe rates, checked against a
// waveform-level model of the BMC line (one entry of {oe,out} per strobe tick).
module tb_apb_ucpd_bmc_tx;

`ifdef UCPD_TX_PREAMBLE_EN
   localparam int PRE_N = 64;
`else
   localparam int PRE_N = 0;
`endif

   typedef struct packed {
      logic [4:0] data;
      logic       last;
   } sym_t;

   logic       ic_clk = 1'b0;
   logic       ic_rst = 1'b1;
   logic       hbit_clk_red = 1'b0;
   logic       tx_start = 1'b0;
   logic       tx_abort = 1'b0;
   logic [4:0] sym_data = 5'd0;
   logic       sym_valid = 1'b0;
   logic       sym_last = 1'b0;
   logic       sym_ready, bmc_out, bmc_oe, bmc_en, tx_done, tx_underrun;

   int         checks = 0;
   int         errors = 0;
   int         tick_period = 4;
   int         cyc = 0;
   int         done_cnt = 0;
   int         und_cnt = 0;
   int         done0, und0;
   bit         stop_feed = 1'b0;
   bit         timed_out;
   logic [5:0] rst_snap;
   logic       mon_tick;

   sym_t       feed_q[$];
   logic [1:0] trace_q[$];
   logic [1:0] exp_q[$];

   apb_ucpd_bmc_tx dut (
      .ic_clk       (ic_clk),
      .ic_rst       (ic_rst),
      .hbit_clk_red (hbit_clk_red),
      .tx_start     (tx_start),
      .tx_abort     (tx_abort),
      .sym_data     (sym_data),
      .sym_valid    (sym_valid),
      .sym_last     (sym_last),
      .sym_ready    (sym_ready),
      .bmc_out      (bmc_out),
      .bmc_oe       (bmc_oe),
      .bmc_en       (bmc_en),
      .tx_done      (tx_done),
      .tx_underrun  (tx_underrun)
   );

   initial forever #5 ic_clk = ~ic_clk;

   // Half-bit strobe, one clock wide every tick_period clocks.
   initial forever begin
      @(posedge ic_clk);
      #1;
      cyc++;
      hbit_clk_red = (cyc % tick_period) == 0;
   end

   // Line monitor: record {oe,out} after every tick taken while busy, count pulses.
   initial forever begin
      @(posedge ic_clk);
      mon_tick = hbit_clk_red;
      #3;
      if (tx_done === 1'b1) done_cnt++;
      if (tx_underrun === 1'b1) und_cnt++;
      if (mon_tick && (bmc_en === 1'b1 || tx_done === 1'b1))
         trace_q.push_back({bmc_oe, bmc_out});
   end

   task automatic fill_random(input int n, input bit withhold);
      sym_t s;
      feed_q.delete();
      for (int i = 0; i < n; i++) begin
         s.data = 5'($urandom_range(0, 31));
         s.last = !withhold && (i == n - 1);
         feed_q.push_back(s);
      end
   endtask

   // Expected line: transition at every bit start, extra one mid-bit for a 1,
   // an idle tick on underrun, then toggle / drive 0 / release.
   task automatic build_exp(input bit underrun);
      logic       lvl;
      logic       bits[$];
      logic [4:0] d;
      exp_q.delete();
      lvl = 1'b0;
      for (int k = 0; k < PRE_N; k++) bits.push_back(k[0]);
      foreach (feed_q[i]) begin
         d = feed_q[i].data;
         for (int b = 0; b < 5; b++) bits.push_back(d[b]);
      end
      foreach (bits[i]) begin
         lvl = ~lvl;
         exp_q.push_back({1'b1, lvl});
         if (bits[i]) lvl = ~lvl;
         exp_q.push_back({1'b1, lvl});
      end
      if (underrun) exp_q.push_back({1'b1, lvl});
      exp_q.push_back({1'b1, ~lvl});
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
   endtask

   function automatic int first_diff();
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= trace_q.size() || trace_q[i] !== exp_q[i]) return i;
      if (trace_q.size() != exp_q.size()) return exp_q.size();
      return -1;
   endfunction

   task automatic feeder();
      bit acc;
      for (int i = 0; i < feed_q.size(); i++) begin
         acc = 1'b0;
         sym_data  = feed_q[i].data;
         sym_last  = feed_q[i].last;
         sym_valid = 1'b1;
         for (int w = 0; w < 5000 && !acc && !stop_feed; w++) begin
            @(negedge ic_clk);
            acc = sym_ready;
            @(posedge ic_clk);
            #1;
         end
         if (!acc) break;
      end
      sym_valid = 1'b0;
      sym_last  = 1'b0;
   endtask

   // act: 0 none, 1 abort, 2 reset, applied once act_k ticks have been recorded.
   task automatic run_frame(input int act, input int act_k);
      int budget;
      int c;
      bit fired;
      trace_q.delete();
      done0 = done_cnt;
      und0 = und_cnt;
      stop_feed = 1'b0;
      fired = 1'b0;
      timed_out = 1'b0;
      budget = (PRE_N + 5 * feed_q.size() + 10) * 2 * tick_period + 200;
      @(posedge ic_clk); #1; tx_start = 1'b1;
      @(posedge ic_clk); #1; tx_start = 1'b0;
      fork
         feeder();
         begin
            for (c = 0; c < budget; c++) begin
               @(negedge ic_clk);
               if (act != 0 && !fired && trace_q.size() == act_k) begin
                  fired = 1'b1;
                  stop_feed = 1'b1;
                  if (act == 1) begin
                     tx_abort = 1'b1;
                     @(negedge ic_clk);
                     tx_abort = 1'b0;
                  end else begin
                     ic_rst = 1'b1;
                     @(negedge ic_clk);
                     rst_snap = {bmc_out, bmc_oe, bmc_en, tx_done, tx_underrun, sym_ready};
                     ic_rst = 1'b0;
                     break;
                  end
               end
               if (done_cnt != done0) break;
            end
            if (c >= budget) timed_out = 1'b1;
         end
      join
      repeat (4) @(posedge ic_clk);
      #1;
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL frame_timeout: frame not finished after %0d cycles, need tx_done", budget);
      end
   endtask

   task automatic test_reset();
      ic_rst = 1'b1;
      repeat (3) @(posedge ic_clk);
      @(negedge ic_clk);
      checks++;
      if ({bmc_out, bmc_oe, bmc_en, tx_done, tx_underrun, sym_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 000001",
                  {bmc_out, bmc_oe, bmc_en, tx_done, tx_underrun, sym_ready});
      end
      ic_rst = 1'b0;
      repeat (20) @(posedge ic_clk);
      @(negedge ic_clk);
      checks++;
      if (bmc_en !== 1'b0 || bmc_oe !== 1'b0 || done_cnt != 0) begin
         errors++;
         $display("FAIL idle_after_reset: en %b oe %b done %0d, want 0 0 0", bmc_en, bmc_oe, done_cnt);
      end
   endtask

   task automatic test_single_symbol();
      sym_t s;
      int   bad;
      tick_period = 4;
      feed_q.delete();
      s.data = 5'b11000;
      s.last = 1'b1;
      feed_q.push_back(s);
      build_exp(1'b0);
      run_frame(0, 0);
      bad = first_diff();
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL single_trace: first diff at tick %0d, len %0d want %0d", bad, trace_q.size(), exp_q.size());
      end
      checks++;
      if (done_cnt - done0 != 1 || und_cnt != und0) begin
         errors++;
         $display("FAIL single_status: done %0d und %0d, want 1 0", done_cnt - done0, und_cnt - und0);
      end
      checks++;
      if (bmc_oe !== 1'b0 || bmc_out !== 1'b0 || sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_end: oe %b out %b ready %b, want 0 0 1", bmc_oe, bmc_out, sym_ready);
      end
   endtask

   task automatic test_back_to_back();
      sym_t       s;
      int         bad;
      logic [4:0] fixed_v[3];
      fixed_v[0] = 5'h1F;
      fixed_v[1] = 5'h00;
      fixed_v[2] = 5'h15;
      for (int f = 0; f < 5; f++) begin
         tick_period = (f == 0) ? 4 : int'($urandom_range(2, 6));
         if (f == 0) begin
            feed_q.delete();
            for (int i = 0; i < 3; i++) begin
               s.data = fixed_v[i];
               s.last = (i == 2);
               feed_q.push_back(s);
            end
         end else begin
            fill_random(int'($urandom_range(1, 4)), 1'b0);
         end
         build_exp(1'b0);
         run_frame(0, 0);
         bad = first_diff();
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL b2b_trace[%0d]: first diff at tick %0d, len %0d want %0d", f, bad, trace_q.size(), exp_q.size());
         end
         checks++;
         if (done_cnt - done0 != 1 || und_cnt != und0) begin
            errors++;
            $display("FAIL b2b_status[%0d]: done %0d und %0d, want 1 0", f, done_cnt - done0, und_cnt - und0);
         end
      end
   endtask

   task automatic test_underrun();
      int bad;
      tick_period = int'($urandom_range(2, 5));
      fill_random(1, 1'b1);
      build_exp(1'b1);
      run_frame(0, 0);
      bad = first_diff();
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL underrun_trace: first diff at tick %0d, len %0d want %0d", bad, trace_q.size(), exp_q.size());
      end
      checks++;
      if (und_cnt - und0 != 1 || done_cnt - done0 != 1) begin
         errors++;
         $display("FAIL underrun_status: und %0d done %0d, want 1 1", und_cnt - und0, done_cnt - done0);
      end
      checks++;
      if (bmc_out !== 1'b0 || bmc_oe !== 1'b0) begin
         errors++;
         $display("FAIL underrun_end: out %b oe %b, want 0 0", bmc_out, bmc_oe);
      end
   endtask

   task automatic test_abort();
      int         k;
      int         bad;
      logic [1:0] last_e;
      tick_period = 4;
      fill_random(3, 1'b0);
      k = (PRE_N > 0) ? 21 : int'($urandom_range(1, 29));
      build_exp(1'b0);
      last_e = exp_q[k - 1];
      while (exp_q.size() > k) void'(exp_q.pop_back());
      exp_q.push_back({1'b1, ~last_e[0]});
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
      run_frame(1, k);
      bad = first_diff();
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL abort_trace: k %0d first diff at tick %0d, len %0d want %0d", k, bad, trace_q.size(), exp_q.size());
      end
      checks++;
      if (done_cnt - done0 != 1 || und_cnt != und0) begin
         errors++;
         $display("FAIL abort_status: done %0d und %0d, want 1 0", done_cnt - done0, und_cnt - und0);
      end
      // Next frame must start from a clean state.
      fill_random(2, 1'b0);
      build_exp(1'b0);
      run_frame(0, 0);
      bad = first_diff();
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL post_abort_trace: first diff at tick %0d, len %0d want %0d", bad, trace_q.size(), exp_q.size());
      end
   endtask

   task automatic test_start_abort_same();
      done0 = done_cnt;
      trace_q.delete();
      tick_period = 3;
      @(posedge ic_clk); #1;
      tx_start = 1'b1;
      tx_abort = 1'b1;
      @(posedge ic_clk); #1;
      tx_start = 1'b0;
      tx_abort = 1'b0;
      repeat (40) @(posedge ic_clk);
      @(negedge ic_clk);
      checks++;
      if (bmc_oe !== 1'b0 || bmc_en !== 1'b0 || done_cnt != done0 || trace_q.size() != 0) begin
         errors++;
         $display("FAIL start_abort: oe %b en %b done %0d ticks %0d, want 0 0 0 0",
                  bmc_oe, bmc_en, done_cnt - done0, trace_q.size());
      end
   endtask

   task automatic test_reset_mid_data();
      int bad;
      tick_period = 4;
      fill_random(2, 1'b0);
      run_frame(2, 2 * PRE_N + int'($urandom_range(2, 8)));
      checks++;
      if (rst_snap !== 6'b000001) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %b want 000001", rst_snap);
      end
      repeat (60) @(posedge ic_clk);
      @(negedge ic_clk);
      checks++;
      if (done_cnt != done0 || bmc_en !== 1'b0 || bmc_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet: done %0d en %b oe %b, want 0 0 0", done_cnt - done0, bmc_en, bmc_oe);
      end
      fill_random(1, 1'b0);
      build_exp(1'b0);
      run_frame(0, 0);
      bad = first_diff();
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL post_reset_trace: first diff at tick %0d, len %0d want %0d", bad, trace_q.size(), exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_symbol();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_start_abort_same();
      test_reset_mid_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
